// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// ASCII codes that the downstream grammar checker looks for.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        DATA      = ST_DATA,
        STOP      = ST_STOP,
        WAIT_HIGH = ST_WAIT_HIGH
    } uart_state_e;

    localparam int UART_DATA_BITS           = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 104;

    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_T = 8'h54;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for an asynchronous single-bit input; every stage
// resets to 1 so an idle-high line does not look like a start bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_r;

    // Shift chain, oldest sample in the top bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_r <= {STAGES{1'b1}};
        end else begin
            ff_r <= {ff_r[STAGES-2:0], d};
        end
    end

    assign q = ff_r[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: mid-bit sampling, start-glitch rejection, one-cycle
// data_valid / frame_err strobes and break handling via WAIT_HIGH.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam int             HALF    = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]  BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  BAUD_1  = CW'(32'd1);

    logic                      rx_s;
    uart_state_e               state_r, state_s;
    logic [CW-1:0]             baud_r, baud_s;
    logic [2:0]                bit_idx_r, bit_idx_s;
    logic [UART_DATA_BITS-1:0] shift_r, shift_s;
    logic [UART_DATA_BITS-1:0] data_out_r, data_out_s;
    logic                      data_valid_r, data_valid_s;
    logic                      frame_err_r, frame_err_s;
    logic                      busy_r;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state, counters, shift register and strobe generation.
    always_comb begin
        state_s      = state_r;
        baud_s       = baud_r;
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        data_out_s   = data_out_r;
        data_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                baud_s = {CW{1'b0}};
                if (!rx_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_r == HALF_M1) begin
                    baud_s = {CW{1'b0}};
                    if (rx_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    baud_s = baud_r + BAUD_1;
                end
            end
            DATA: begin
                if (baud_r == BIT_M1) begin
                    baud_s           = {CW{1'b0}};
                    shift_s[bit_idx_r] = rx_s;
                    if (bit_idx_r == 3'd7) begin
                        state_s   = STOP;
                        bit_idx_s = 3'd0;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_1;
                end
            end
            STOP: begin
                if (baud_r == BIT_M1) begin
                    baud_s = {CW{1'b0}};
                    if (rx_s) begin
                        data_out_s   = shift_r;
                        data_valid_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = WAIT_HIGH;
                    end
                end else begin
                    baud_s = baud_r + BAUD_1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) parks here so it reports only once.
                if (rx_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            default: begin
                state_s   = IDLE;
                baud_s    = {CW{1'b0}};
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            baud_r       <= {CW{1'b0}};
            bit_idx_r    <= 3'd0;
            shift_r      <= {UART_DATA_BITS{1'b0}};
            data_out_r   <= {UART_DATA_BITS{1'b0}};
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            baud_r       <= baud_s;
            bit_idx_r    <= bit_idx_s;
            shift_r      <= shift_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            frame_err_r  <= frame_err_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule
